sprite_draw_scheduler: RTL and testbench

Shares the single VGA plot port among up to `NUM_REQ` sprite sources (player ship, enemies, bullets). Each source raises a request carrying a sprite origin and colour. The block grants sources round-robin and rasterises a `SPR_W`×`SPR_H` box one pixel per clock onto `x_out`/`y_out`/`col_out`/`plot`, clipping off-screen pixels. It sits between the game-object logic and the VGA adapter and is the only writer of the plot port.

---
 rtl/starflux_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/sprite_draw_scheduler.sv | 165 ++++++++++++++++
 tb/tb_sprite_draw_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/starflux_pkg.sv
// Shared constants and FSM state type for the sprite draw path.
// Screen geometry, coordinate/colour widths and the scheduler state encoding.
package starflux_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 7;
  localparam int unsigned COL_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or above the
// pointer, wrapping around. Purely combinational; the pointer lives in the
// parent.
//   i_req       : per-source request vector
//   i_rr_ptr    : index where the search starts
//   o_gnt_idx   : granted source index (0 when nothing is requested)
//   o_gnt_valid : at least one request is asserted
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [IDX_W-1:0]   o_gnt_idx,
  output logic               o_gnt_valid
);

  logic [IDX_W-1:0] w_idx;

  // Scan from farthest to nearest so the last hit is the first in search order.
  always_comb begin
    o_gnt_idx   = '0;
    o_gnt_valid = 1'b0;
    w_idx       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = IDX_W'((32'(i_rr_ptr) + 32'(i)) % NUM_REQ);
      if (i_req[w_idx]) begin
        o_gnt_idx   = w_idx;
        o_gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Sprite draw scheduler: shares the single VGA plot port among NUM_REQ
// sprite sources, granting round-robin and rasterising an SPR_W x SPR_H box
// one pixel per clock with off-screen pixels clipped.
//   clk, reset : system clock, asynchronous active-high reset
//   req        : per-source level request
//   req_x/y/col: packed per-source origin and colour
//   x_out/y_out/col_out/plot : pixel write to the VGA adapter
//   done       : one-hot, one-cycle completion pulse for the granted source
//   busy       : scheduler is not idle
module sprite_draw_scheduler
  import starflux_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned SPR_W   = 4,
  parameter int unsigned SPR_H   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [X_W*NUM_REQ-1:0]   req_x,
  input  logic [Y_W*NUM_REQ-1:0]   req_y,
  input  logic [COL_W*NUM_REQ-1:0] req_col,
  output logic [X_W-1:0]           x_out,
  output logic [Y_W-1:0]           y_out,
  output logic [COL_W-1:0]         col_out,
  output logic                     plot,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CX_W  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int unsigned CY_W  = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int unsigned XS_W  = X_W + 1;
  localparam int unsigned YS_W  = Y_W + 1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_gnt;
  logic [X_W-1:0]   r_base_x;
  logic [Y_W-1:0]   r_base_y;
  logic [COL_W-1:0] r_col;
  logic [CX_W-1:0]  r_cx;
  logic [CY_W-1:0]  r_cy;

  logic [IDX_W-1:0] w_gnt_idx;
  logic             w_gnt_valid;
  logic             w_grant;
  logic             w_advance;
  logic             w_row_end;
  logic             w_last_px;
  logic [X_W-1:0]   w_sel_x;
  logic [Y_W-1:0]   w_sel_y;
  logic [COL_W-1:0] w_sel_col;
  logic [XS_W-1:0]  w_x_sum;
  logic [YS_W-1:0]  w_y_sum;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req       (req),
    .i_rr_ptr    (r_rr_ptr),
    .o_gnt_idx   (w_gnt_idx),
    .o_gnt_valid (w_gnt_valid)
  );

  assign w_row_end = (r_cx == CX_W'(SPR_W - 1));
  assign w_last_px = w_row_end && (r_cy == CY_W'(SPR_H - 1));

  // Next-state and control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_advance   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_grant     = 1'b1;
          w_state_nxt = DRAW;
        end
      end
      DRAW: begin
        w_advance = 1'b1;
        if (w_last_px) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Select the granted source's origin and colour.
  always_comb begin
    w_sel_x   = '0;
    w_sel_y   = '0;
    w_sel_col = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_idx == IDX_W'(i)) begin
        w_sel_x   = req_x[i*X_W +: X_W];
        w_sel_y   = req_y[i*Y_W +: Y_W];
        w_sel_col = req_col[i*COL_W +: COL_W];
      end
    end
  end

  // Grant latches, round-robin pointer and raster counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_gnt    <= '0;
      r_base_x <= '0;
      r_base_y <= '0;
      r_col    <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
      r_gnt    <= w_gnt_idx;
      r_base_x <= w_sel_x;
      r_base_y <= w_sel_y;
      r_col    <= w_sel_col;
      r_cx     <= '0;
      r_cy     <= '0;
    end else if (w_advance) begin
      if (w_row_end) begin
        r_cx <= '0;
        r_cy <= w_last_px ? '0 : r_cy + CY_W'(1);
      end else begin
        r_cx <= r_cx + CX_W'(1);
      end
    end
  end

  // One bit of headroom so pixels wrapping past 255/127 are still clipped.
  assign w_x_sum = {1'b0, r_base_x} + XS_W'(r_cx);
  assign w_y_sum = {1'b0, r_base_y} + YS_W'(r_cy);

  assign x_out   = w_x_sum[X_W-1:0];
  assign y_out   = w_y_sum[Y_W-1:0];
  assign col_out = r_col;
  assign plot    = (r_state == DRAW)
                && (w_x_sum < XS_W'(SCREEN_W))
                && (w_y_sum < YS_W'(SCREEN_H));
  assign busy    = (r_state != IDLE);

  // Completion pulse to the source that owned this draw.
  always_comb begin
    done = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      done[i] = (r_state == DONE) && (r_gnt == IDX_W'(i));
    end
  end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Self-checking bench for sprite_draw_scheduler: directed scenarios plus
// randomized traffic compared against a transaction-level schedule model.
module tb_sprite_draw_scheduler;

  localparam int NR = 4;
  localparam int SW = 4;
  localparam int SH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req;
  logic [8*NR-1:0] req_x;
  logic [7*NR-1:0] req_y;
  logic [3*NR-1:0] req_col;
  logic [7:0]      x_out;
  logic [6:0]      y_out;
  logic [2:0]      col_out;
  logic            plot;
  logic [NR-1:0]   done;
  logic            busy;

  sprite_draw_scheduler #(
    .NUM_REQ (NR),
    .SPR_W   (SW),
    .SPR_H   (SH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .req_x   (req_x),
    .req_y   (req_y),
    .req_col (req_col),
    .x_out   (x_out),
    .y_out   (y_out),
    .col_out (col_out),
    .plot    (plot),
    .done    (done),
    .busy    (busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit draw;
    bit plot;
    int x;
    int y;
    int col;
    int done_v;
  } exp_t;

  exp_t            exp_q[$];
  int              done_obs[$];
  int              m_ptr;
  int              n_cmp;
  int              n_err;
  int              plot_cnt;
  logic [8*NR-1:0] vx;
  logic [7*NR-1:0] vy;
  logic [3*NR-1:0] vc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Model: a granted sprite is SW*SH pixel cycles followed by one done cycle.
  task automatic model_grant(input logic [NR-1:0] r);
    int   g;
    int   bx;
    int   by;
    int   c;
    exp_t e;
    g = -1;
    for (int i = 0; i < NR; i++) begin
      int k;
      k = (m_ptr + i) % NR;
      if (g < 0 && r[k]) g = k;
    end
    m_ptr = (g + 1) % NR;
    bx = int'(vx[8*g +: 8]);
    by = int'(vy[7*g +: 7]);
    c  = int'(vc[3*g +: 3]);
    for (int yy = 0; yy < SH; yy++) begin
      for (int xx = 0; xx < SW; xx++) begin
        e.draw   = 1'b1;
        e.x      = (bx + xx) % 256;
        e.y      = (by + yy) % 128;
        e.plot   = ((bx + xx) < 160) && ((by + yy) < 120);
        e.col    = c;
        e.done_v = 0;
        exp_q.push_back(e);
      end
    end
    e = '{default: 0};
    e.done_v = 1 << g;
    exp_q.push_back(e);
  endtask

  // Check the current cycle, then drive inputs for the coming edge.
  task automatic step(input logic [NR-1:0] r);
    exp_t e;
    bit   idle;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      idle = 1'b0;
    end else begin
      e    = '{default: 0};
      idle = 1'b1;
    end
    check("busy", 32'(busy), 32'(e.draw || (e.done_v != 0)));
    check("plot", 32'(plot), 32'(e.plot));
    check("done", 32'(done), 32'(e.done_v));
    if (e.draw) begin
      check("x_out", 32'(x_out), 32'(e.x));
      check("y_out", 32'(y_out), 32'(e.y));
      check("col_out", 32'(col_out), 32'(e.col));
    end
    if (plot === 1'b1) plot_cnt++;
    for (int k = 0; k < NR; k++) if (done[k] === 1'b1) done_obs.push_back(k);
    req     = r;
    req_x   = vx;
    req_y   = vy;
    req_col = vc;
    if (idle && (r != '0)) model_grant(r);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) step('0);
    step('0);
  endtask

  // Grant, 16 pixel cycles with the request held, then the done cycle.
  task automatic sprite(input logic [NR-1:0] r);
    drain();
    plot_cnt = 0;
    for (int i = 0; i < 1 + SW*SH; i++) step(r);
    step('0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_plot"}, 32'(plot), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_x"}, 32'(x_out), 32'd0);
    check({tag, "_y"}, 32'(y_out), 32'd0);
    check({tag, "_col"}, 32'(col_out), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_exp[5];
    logic [NR-1:0] cur;
    rr_exp = '{0, 1, 2, 3, 0};
    n_cmp = 0; n_err = 0; plot_cnt = 0; m_ptr = 0;
    vx = '0; vy = '0; vc = '0;
    req = '0; req_x = '0; req_y = '0; req_col = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Round-robin with every source requesting continuously.
    for (int i = 0; i < NR; i++) begin
      vx[8*i +: 8] = 8'(20 * i);
      vy[7*i +: 7] = 7'(10 * i);
      vc[3*i +: 3] = 3'(i + 1);
    end
    done_obs.delete();
    for (int i = 0; i < 4*(SW*SH + 2) + 1; i++) step(4'b1111);
    drain();
    check("rr_count", 32'(done_obs.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check("rr_order", (i < done_obs.size()) ? 32'(done_obs[i]) : 32'hFFFF_FFFF, 32'(rr_exp[i]));

    // Single request fully on screen.
    vx[7:0] = 8'd10; vy[6:0] = 7'd20; vc[2:0] = 3'b100;
    sprite(4'b0001);
    check("single_plots", 32'(plot_cnt), 32'd16);

    // Clipping at the bottom-right corner.
    vx[15:8] = 8'd158; vy[13:7] = 7'd118;
    sprite(4'b0010);
    check("clip_plots", 32'(plot_cnt), 32'd4);

    // 8-bit wrap: every pixel off screen.
    vx[23:16] = 8'd254; vy[20:14] = 7'd0;
    sprite(4'b0100);
    check("wrap_plots", 32'(plot_cnt), 32'd0);

    // Coordinates and colour changing mid-draw must be ignored.
    drain();
    vx[31:24] = 8'd40; vy[27:21] = 7'd50; vc[11:9] = 3'd5;
    for (int i = 0; i < 9; i++) step(4'b1000);
    vx[31:24] = 8'd99; vy[27:21] = 7'd3; vc[11:9] = 3'd2;
    for (int i = 0; i < 8; i++) step(4'b1000);
    step('0);

    // Reset on the 5th DRAW cycle aborts without a done pulse.
    drain();
    vx[15:8] = 8'd30; vy[13:7] = 7'd40; vc[5:3] = 3'd6;
    for (int i = 0; i < 5; i++) step(4'b0010);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("midreset");
    exp_q.delete();
    m_ptr = 0;
    @(negedge clk);
    req   = '0;
    reset = 1'b0;
    sprite(4'b0011);
    check("after_reset_plots", 32'(plot_cnt), 32'd16);

    // Randomized traffic.
    cur = '0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) cur = 4'($urandom);
      for (int i = 0; i < NR; i++) begin
        vx[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(150, 255))
                                                   : 8'($urandom_range(0, 159));
        vy[7*i +: 7] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(110, 127))
                                                   : 7'($urandom_range(0, 119));
        vc[3*i +: 3] = 3'($urandom);
      end
      step(cur);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
